// File: rtl/sdram_wr_buffer_if.sv
// Handshake and status bundle between the audio sample
// source, the SDRAM write module and sdram_wr_buffer.
interface sdram_wr_buffer_if #(
   parameter int DEPTH     = 16,
   parameter int COL_BITS  = 9,
   parameter int ROW_BITS  = 12,
   parameter int BANK_BITS = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 sample_valid;
   logic [15:0]          sample_data;
   logic                 sample_ready;
   logic                 wr_trigger;
   logic                 wr_data_req;
   logic [15:0]          wr_data;
   logic                 wr_done;
   logic [BANK_BITS-1:0] wr_bank;
   logic [ROW_BITS-1:0]  wr_row;
   logic [COL_BITS-1:0]  wr_col;
   logic [CW-1:0]        fill_level;
   logic                 busy;
   logic                 overflow;
   logic                 underrun;

   modport master (
      output sample_valid, sample_data,
      output wr_data_req, wr_done,
      input  sample_ready, wr_trigger, wr_data,
      input  wr_bank, wr_row, wr_col,
      input  fill_level, busy, overflow, underrun
   );

   modport slave (
      input  sample_valid, sample_data,
      input  wr_data_req, wr_done,
      output sample_ready, wr_trigger, wr_data,
      output wr_bank, wr_row, wr_col,
      output fill_level, busy, overflow, underrun
   );
endinterface

// File: rtl/sdram_wr_buffer.sv
// Show-ahead sample FIFO that hands bursts of words to the
// SDRAM write module and tracks the linear burst address.
module sdram_wr_buffer #(
   parameter int DEPTH     = 16,
   parameter int BURST_LEN = 8,
   parameter int COL_BITS  = 9,
   parameter int ROW_BITS  = 12,
   parameter int BANK_BITS = 2
) (
   input  logic sys_clk,
   input  logic sys_rst,
   sdram_wr_buffer_if.slave bus
);
   localparam int AW = BANK_BITS + ROW_BITS + COL_BITS;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(BURST_LEN) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [1:0]    state;
   logic [NW-1:0] wcnt;
   logic [AW-1:0] addr;
   logic          trig;
   logic          ovf;
   logic          und;
   logic          ready;
   logic          push;
   logic          pop;
   logic          serving;
   logic          full_burst;

   assign ready      = count < CW'(DEPTH);
   assign push       = bus.sample_valid & ready;
   assign serving    = (state == S_REQ) | (state == S_BURST);
   assign pop        = bus.wr_data_req & serving & (count != '0);
   assign full_burst = count >= CW'(BURST_LEN);

   assign bus.sample_ready = ready;
   assign bus.wr_trigger   = trig;
   assign bus.wr_data      = mem[rd_ptr];
   assign bus.fill_level   = count;
   assign bus.busy         = state != S_IDLE;
   assign bus.overflow     = ovf;
   assign bus.underrun     = und;
   assign {bus.wr_bank, bus.wr_row, bus.wr_col} = addr;

   // sample storage; contents need no reset
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr] <= bus.sample_data;
   end

   // pointers wrap naturally at DEPTH; count tracks occupancy
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // burst sequencer: trigger, serve BURST_LEN words, await done
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= S_IDLE;
         wcnt  <= '0;
         addr  <= '0;
         trig  <= 1'b0;
      end else begin
         trig <= 1'b0;
         unique case (1'b1)
            (state == S_IDLE): begin
               if (full_burst) begin
                  state <= S_REQ;
                  trig  <= 1'b1;
               end
            end
            (state == S_REQ): begin
               if (pop) begin
                  wcnt  <= NW'(1);
                  state <= (BURST_LEN == 1) ? S_WAIT : S_BURST;
               end
            end
            (state == S_BURST): begin
               if (pop) begin
                  wcnt <= wcnt + NW'(1);
                  if (wcnt == NW'(BURST_LEN - 1)) state <= S_WAIT;
               end
            end
            (state == S_WAIT): begin
               if (bus.wr_done) begin
                  addr  <= addr + AW'(BURST_LEN);
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // sticky error flags, cleared only by reset
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ovf <= 1'b0;
         und <= 1'b0;
      end else begin
         if (bus.sample_valid & ~ready) ovf <= 1'b1;
         if (bus.wr_data_req & ~pop)    und <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sdram_wr_buffer.sv
// Randomised and directed bench for sdram_wr_buffer against
// a queue-based model of the burst buffer behaviour.
module tb_sdram_wr_buffer;
   localparam int DEPTH = 16;
   localparam int BL    = 8;
   localparam int COLB  = 4;
   localparam int ROWB  = 2;
   localparam int BANKB = 1;
   localparam int AW    = COLB + ROWB + BANKB;
   localparam int ASZ   = 1 << AW;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   sdram_wr_buffer_if #(
      .DEPTH(DEPTH), .COL_BITS(COLB),
      .ROW_BITS(ROWB), .BANK_BITS(BANKB)
   ) bus ();

   sdram_wr_buffer #(
      .DEPTH(DEPTH), .BURST_LEN(BL), .COL_BITS(COLB),
      .ROW_BITS(ROWB), .BANK_BITS(BANKB)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus(bus)
   );

   // model: 0 idle, 1 triggered, 2 bursting, 3 awaiting done
   int q[$];
   int ph;
   int wn;
   int maddr;
   bit mtrig;
   bit movf;
   bit mund;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit v, input int d,
                             input bit req, input bit done,
                             input bit rst);
      bit can_pop;
      bit nt;
      if (rst) begin
         q.delete();
         ph = 0; wn = 0; maddr = 0;
         mtrig = 0; movf = 0; mund = 0;
         return;
      end
      can_pop = req && (ph == 1 || ph == 2) && q.size() > 0;
      if (v && q.size() >= DEPTH) movf = 1;
      if (req && !can_pop) mund = 1;
      nt = (ph == 0) && (q.size() >= BL);
      case (ph)
         0: if (q.size() >= BL) ph = 1;
         1: if (can_pop) begin
               wn = 1;
               ph = (BL == 1) ? 3 : 2;
            end
         2: if (can_pop) begin
               wn++;
               if (wn == BL) ph = 3;
            end
         3: if (done) begin
               maddr = (maddr + BL) % ASZ;
               ph = 0;
            end
         default: ph = 0;
      endcase
      if (v && q.size() < DEPTH) begin
         if (can_pop) void'(q.pop_front());
         q.push_back(d & 16'hffff);
      end else if (can_pop) begin
         void'(q.pop_front());
      end
      mtrig = nt;
   endtask

   task automatic check_all();
      chk("fill", 32'(bus.fill_level), q.size());
      chk("ready", 32'(bus.sample_ready), 32'(q.size() < DEPTH));
      chk("trig", 32'(bus.wr_trigger), 32'(mtrig));
      chk("busy", 32'(bus.busy), 32'(ph != 0));
      chk("ovf", 32'(bus.overflow), 32'(movf));
      chk("und", 32'(bus.underrun), 32'(mund));
      chk("col", 32'(bus.wr_col), maddr % (1 << COLB));
      chk("row", 32'(bus.wr_row),
          (maddr / (1 << COLB)) % (1 << ROWB));
      chk("bank", 32'(bus.wr_bank),
          maddr / (1 << (COLB + ROWB)));
      if (q.size() > 0) chk("data", 32'(bus.wr_data), q[0]);
   endtask

   task automatic step(input bit v, input int d,
                       input bit req, input bit done,
                       input bit rst);
      bus.sample_valid = v;
      bus.sample_data  = d[15:0];
      bus.wr_data_req  = req;
      bus.wr_done      = done;
      sys_rst          = rst;
      @(posedge sys_clk);
      model_edge(v, d, req, done, rst);
      @(negedge sys_clk);
      check_all();
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
   endtask

   task automatic push_n(input int n, input int base);
      for (int i = 0; i < n; i++) step(1, base + i, 0, 0, 0);
   endtask

   task automatic wait_trig();
      int k;
      k = 0;
      while (ph != 1 && k < 40) begin
         step(0, 0, 0, 0, 0);
         k++;
      end
      if (ph != 1) chk("trig_timeout", 0, 1);
   endtask

   task automatic burst_run(input int base);
      for (int i = 0; i < BL; i++) begin
         if (base >= 0) chk("seq", 32'(bus.wr_data), base + i);
         step(0, 0, 1, 0, 0);
      end
      step(0, 0, 0, 1, 0);
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      bus.wr_data_req  = 1'b0;
      bus.wr_done      = 1'b0;

      do_reset();
      chk("rst_fill", 32'(bus.fill_level), 0);
      chk("rst_ready", 32'(bus.sample_ready), 1);

      push_n(BL, 1);
      chk("t1_pre", 32'(bus.wr_trigger), 0);
      step(0, 0, 0, 0, 0);
      chk("t1_trig", 32'(bus.wr_trigger), 1);
      chk("t1_col", 32'(bus.wr_col), 0);
      step(0, 0, 0, 0, 0);
      chk("t1_pulse", 32'(bus.wr_trigger), 0);

      burst_run(1);
      chk("t2_fill", 32'(bus.fill_level), 0);
      chk("t2_col", 32'(bus.wr_col), 8);
      chk("t2_busy", 32'(bus.busy), 0);

      do_reset();
      push_n(DEPTH, 1);
      chk("t3_full", 32'(bus.sample_ready), 0);
      step(1, 17, 0, 0, 0);
      chk("t3_ovf", 32'(bus.overflow), 1);
      chk("t3_fill", 32'(bus.fill_level), 16);
      wait_trig();
      burst_run(1);
      wait_trig();
      burst_run(9);

      push_n(BL, 16'h100);
      wait_trig();
      for (int i = 0; i < BL; i++) begin
         chk("t4_seq", 32'(bus.wr_data), 16'h100 + i);
         step(1, 16'h200 + i, 1, 0, 0);
         chk("t4_fill", 32'(bus.fill_level), BL);
      end
      step(0, 0, 0, 1, 0);
      wait_trig();
      burst_run(16'h200);

      for (int k = 0; k < 20 && maddr != ASZ - BL; k++) begin
         push_n(BL, 16'h300);
         wait_trig();
         burst_run(16'h300);
      end
      chk("t5_pre_col", 32'(bus.wr_col), 8);
      chk("t5_pre_row", 32'(bus.wr_row), 3);
      chk("t5_pre_bank", 32'(bus.wr_bank), 1);
      push_n(BL, 16'h400);
      wait_trig();
      burst_run(16'h400);
      chk("t5_col", 32'(bus.wr_col), 0);
      chk("t5_row", 32'(bus.wr_row), 0);
      chk("t5_bank", 32'(bus.wr_bank), 0);

      push_n(BL, 16'h500);
      wait_trig();
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("t6_fill", 32'(bus.fill_level), 0);
      chk("t6_busy", 32'(bus.busy), 0);
      chk("t6_trig", 32'(bus.wr_trigger), 0);
      chk("t6_und0", 32'(bus.underrun), 0);
      step(0, 0, 1, 0, 0);
      chk("t6_und", 32'(bus.underrun), 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0);
         chk("t6_notrig", 32'(bus.wr_trigger), 0);
      end

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit v;
         bit r;
         bit dn;
         bit rs;
         v  = $urandom_range(0, 99) < 55;
         r  = (ph == 1 || ph == 2) ?
              ($urandom_range(0, 99) < 60) :
              ($urandom_range(0, 99) < 3);
         dn = $urandom_range(0, 99) < 30;
         rs = $urandom_range(0, 999) < 2;
         step(v, int'($urandom), r, dn, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
